// File: rtl/mac_filter.sv
// mac_filter: time-multiplexed single-MAC sample filter.
// Modes (inMode): 00 bypass, 01 FIR, 10 IIR (FIR + feedback), 11 moving average.
// One product per clock; the result is rounded, saturated, registered, and
// then pushed into the output history that the IIR feedback path reads.
module mac_filter #(
    parameter int SAMPLE_W = 12,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 17,
    parameter int FB_TAPS  = 8,
    parameter int FRAC     = 6,
    parameter int AVG_LOG2 = 4,
    parameter int ACC_W    = 40,
    localparam int CA_W    = $clog2(TAPS + FB_TAPS)
) (
    input  logic                       inClk,
    input  logic                       inRst_n,
    input  logic signed [SAMPLE_W-1:0] inSample,
    input  logic                       inSampleReady,
    input  logic [1:0]                 inMode,
    input  logic                       inCoefWe,
    input  logic [CA_W-1:0]            inCoefAddr,
    input  logic signed [COEF_W-1:0]   inCoefData,
    output logic signed [SAMPLE_W-1:0] outSample,
    output logic                       outSampleValid,
    output logic                       outBusy,
    output logic                       outOverrun
);

    localparam int AVG_N   = 1 << AVG_LOG2;
    localparam int HIST    = (TAPS > AVG_N) ? TAPS : AVG_N;
    localparam int CNT_MAX = (HIST > FB_TAPS) ? HIST : FB_TAPS;
    localparam int IDX_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PROD_W  = SAMPLE_W + COEF_W;

    localparam logic [1:0] MODE_BYP = 2'b00;
    localparam logic [1:0] MODE_IIR = 2'b10;
    localparam logic [1:0] MODE_AVG = 2'b11;

    localparam logic [COEF_W-1:0]       B_ONE = COEF_W'(1 << FRAC);
    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SMAX  = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN  = ACC_W'(-(1 << (SAMPLE_W - 1)));

    typedef enum logic [1:0] {IDLE, FF, FB, ROUND} state_t;

    state_t                            state;
    logic [1:0]                        mode_r;
    logic [IDX_W-1:0]                  idx;
    logic signed [ACC_W-1:0]           acc;
    logic [HIST-1:0][SAMPLE_W-1:0]     x_hist;
    logic [FB_TAPS-1:0][SAMPLE_W-1:0]  y_hist;
    logic [TAPS-1:0][COEF_W-1:0]       b_coef;
    logic [FB_TAPS-1:0][COEF_W-1:0]    a_coef;

    logic signed [SAMPLE_W-1:0] xsel, ysel, mul_a;
    logic signed [COEF_W-1:0]   bsel, asel, mul_b;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    addend, rnd;
    logic signed [SAMPLE_W-1:0] sat;
    logic                       ff_last, fb_last;

    // Operand mux, product, accumulate term, and round/saturate of the accumulator
    always_comb begin
        xsel = '0;
        ysel = '0;
        bsel = '0;
        asel = '0;
        for (int k = 0; k < HIST; k++)
            if (idx == IDX_W'(k)) xsel = x_hist[k];
        for (int k = 0; k < TAPS; k++)
            if (idx == IDX_W'(k)) bsel = b_coef[k];
        for (int k = 0; k < FB_TAPS; k++)
            if (idx == IDX_W'(k)) begin
                ysel = y_hist[k];
                asel = a_coef[k];
            end
        mul_a  = (state == FB) ? ysel : xsel;
        mul_b  = (state == FB) ? asel : bsel;
        prod   = PROD_W'(mul_a) * PROD_W'(mul_b);
        // moving average sums raw samples; coefficients play no part
        addend = (mode_r == MODE_AVG && state == FF) ? ACC_W'(mul_a) : ACC_W'(prod);
        ff_last = (mode_r == MODE_AVG) ? (idx == IDX_W'(AVG_N - 1)) : (idx == IDX_W'(TAPS - 1));
        fb_last = (idx == IDX_W'(FB_TAPS - 1));
        rnd = (mode_r == MODE_AVG) ? (acc >>> AVG_LOG2) : ((acc + HALF) >>> FRAC);
        if (rnd > SMAX)      sat = SMAX[SAMPLE_W-1:0];
        else if (rnd < SMIN) sat = SMIN[SAMPLE_W-1:0];
        else                 sat = rnd[SAMPLE_W-1:0];
    end

    // Coefficient store; writes are accepted only while no computation runs
    always_ff @(posedge inClk or negedge inRst_n) begin
        if (!inRst_n) begin
            b_coef    <= '0;
            b_coef[0] <= B_ONE;
            a_coef    <= '0;
        end else if (inCoefWe && !outBusy) begin
            for (int k = 0; k < TAPS; k++)
                if (inCoefAddr == CA_W'(k)) b_coef[k] <= inCoefData;
            for (int k = 0; k < FB_TAPS; k++)
                if (inCoefAddr == CA_W'(TAPS + k)) a_coef[k] <= inCoefData;
        end
    end

    // Sequencer: sample intake, MAC stepping, rounding and output registers
    always_ff @(posedge inClk or negedge inRst_n) begin
        if (!inRst_n) begin
            state          <= IDLE;
            mode_r         <= MODE_BYP;
            idx            <= '0;
            acc            <= '0;
            x_hist         <= '0;
            y_hist         <= '0;
            outSample      <= '0;
            outSampleValid <= 1'b0;
            outBusy        <= 1'b0;
            outOverrun     <= 1'b0;
        end else begin
            outSampleValid <= 1'b0;
            if (inSampleReady && outBusy) outOverrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (inSampleReady) begin
                        for (int k = HIST - 1; k > 0; k--) x_hist[k] <= x_hist[k-1];
                        x_hist[0] <= inSample;
                        mode_r    <= inMode;
                        acc       <= '0;
                        idx       <= '0;
                        if (inMode == MODE_BYP) begin
                            outSample      <= inSample;
                            outSampleValid <= 1'b1;
                        end else begin
                            state   <= FF;
                            outBusy <= 1'b1;
                        end
                    end
                end
                FF: begin
                    acc <= acc + addend;
                    if (ff_last) begin
                        idx   <= '0;
                        state <= (mode_r == MODE_IIR) ? FB : ROUND;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FB: begin
                    acc <= acc + addend;
                    if (fb_last) begin
                        idx   <= '0;
                        state <= ROUND;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ROUND: begin
                    outSample      <= sat;
                    outSampleValid <= 1'b1;
                    for (int k = FB_TAPS - 1; k > 0; k--) y_hist[k] <= y_hist[k-1];
                    y_hist[0]      <= sat;
                    outBusy        <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_filter.sv
// Scoreboard bench for mac_filter: each accepted strobe pushes its expected
// result and arrival cycle; the monitor pops and compares on every valid pulse.
module tb_mac_filter;

    localparam logic [1:0] BYP = 2'b00;
    localparam logic [1:0] FIR = 2'b01;
    localparam logic [1:0] IIR = 2'b10;
    localparam logic [1:0] AVG = 2'b11;

    logic              inClk = 1'b0;
    logic              inRst_n = 1'b1;
    logic signed [11:0] inSample = '0;
    logic              inSampleReady = 1'b0;
    logic [1:0]        inMode = FIR;
    logic              inCoefWe = 1'b0;
    logic [4:0]        inCoefAddr = '0;
    logic signed [15:0] inCoefData = '0;
    logic signed [11:0] outSample;
    logic              outSampleValid;
    logic              outBusy;
    logic              outOverrun;

    mac_filter dut (
        .inClk(inClk), .inRst_n(inRst_n), .inSample(inSample),
        .inSampleReady(inSampleReady), .inMode(inMode), .inCoefWe(inCoefWe),
        .inCoefAddr(inCoefAddr), .inCoefData(inCoefData), .outSample(outSample),
        .outSampleValid(outSampleValid), .outBusy(outBusy), .outOverrun(outOverrun)
    );

    always #5 inClk = ~inClk;

    int cyc = 0;
    always @(posedge inClk) cyc <= cyc + 1;

    typedef struct { int val; int cyc; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int nvec = 0;
    int nerr = 0;

    always @(negedge inClk) begin
        if (inRst_n && outSampleValid) begin
            nvec++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_valid: got outSample=%0d at cycle %0d, required no output", outSample, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (outSample !== mon_e.val) begin
                    nerr++;
                    $display("FAIL sample_value: got %0d, required %0d", outSample, mon_e.val);
                end
                if (cyc !== mon_e.cyc) begin
                    nerr++;
                    $display("FAIL sample_latency: valid at cycle %0d, required cycle %0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge inClk);
        inRst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge inClk);
        inRst_n = 1'b1;
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge inClk);
        inCoefWe   = 1'b1;
        inCoefAddr = 5'(addr);
        inCoefData = 16'(data);
        @(negedge inClk);
        inCoefWe   = 1'b0;
    endtask

    task automatic drive_strobe(input int s, input logic [1:0] m, input int expv, input int lat);
        @(negedge inClk);
        inSample      = 12'(s);
        inMode        = m;
        inSampleReady = 1'b1;
        sb.push_back('{expv, cyc + lat});
        @(negedge inClk);
        inSampleReady = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || outBusy) && n < 300) begin
            @(negedge inClk);
            n++;
        end
        if (n >= 300) begin
            nerr++;
            $display("FAIL %s_timeout: %0d results pending after %0d cycles, required 0", tag, sb.size(), n);
        end
    endtask

    task automatic test_reset();
        #1 inRst_n = 1'b0;
        #1;
        nvec++;
        if (outSample !== 12'sd0) begin nerr++; $display("FAIL reset_sample: got %0d, required 0", outSample); end
        nvec++;
        if (outSampleValid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b, required 0", outSampleValid); end
        nvec++;
        if (outBusy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b, required 0", outBusy); end
        nvec++;
        if (outOverrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun: got %b, required 0", outOverrun); end
        repeat (2) @(negedge inClk);
        inRst_n = 1'b1;
    endtask

    task automatic test_fir_identity();
        int bc = 0;
        drive_strobe(100, FIR, 100, 19);
        for (int i = 0; i < 18; i++) begin
            if (outBusy) bc++;
            @(negedge inClk);
        end
        nvec++;
        if (bc !== 18) begin nerr++; $display("FAIL fir_busy_span: busy for %0d cycles, required 18", bc); end
        nvec++;
        if (outBusy !== 1'b0 || outSampleValid !== 1'b1) begin
            nerr++;
            $display("FAIL fir_done_flags: busy=%b valid=%b, required busy=0 valid=1", outBusy, outSampleValid);
        end
        wait_idle("fir_identity");
    endtask

    task automatic test_fir_impulse();
        do_reset();
        for (int k = 0; k < 17; k++) write_coef(k, 64 * (k + 1));
        drive_strobe(1, FIR, 1, 19);
        wait_idle("fir_impulse");
        for (int k = 1; k < 18; k++) begin
            drive_strobe(0, FIR, (k < 17) ? k + 1 : 0, 19);
            wait_idle("fir_impulse");
        end
    endtask

    task automatic test_moving_avg();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive_strobe(160, AVG, 10 * (k + 1), 18);
            wait_idle("moving_avg");
        end
    endtask

    task automatic test_saturation();
        do_reset();
        write_coef(0, 256);
        drive_strobe(1000, FIR, 2047, 19);
        wait_idle("sat_pos");
        drive_strobe(-1000, FIR, -2048, 19);
        wait_idle("sat_neg");
    endtask

    task automatic test_iir_step();
        int expv[4] = '{50, 75, 88, 94};
        do_reset();
        write_coef(0, 32);
        write_coef(17, 32);
        for (int k = 0; k < 4; k++) begin
            drive_strobe(100, IIR, expv[k], 27);
            wait_idle("iir_step");
        end
    endtask

    task automatic test_overrun_bypass();
        do_reset();
        write_coef(1, 64);
        drive_strobe(200, FIR, 200, 19);
        nvec++;
        if (outOverrun !== 1'b0) begin nerr++; $display("FAIL overrun_early: got %b, required 0", outOverrun); end
        @(negedge inClk);
        // strobe plus coefficient write while busy: both must be ignored
        inSample      = 12'sd555;
        inMode        = BYP;
        inSampleReady = 1'b1;
        inCoefWe      = 1'b1;
        inCoefAddr    = 5'd0;
        inCoefData    = 16'sd0;
        @(negedge inClk);
        inSampleReady = 1'b0;
        inCoefWe      = 1'b0;
        nvec++;
        if (outOverrun !== 1'b1) begin nerr++; $display("FAIL overrun_set: got %b, required 1", outOverrun); end
        wait_idle("overrun_first");
        nvec++;
        if (outOverrun !== 1'b1) begin nerr++; $display("FAIL overrun_sticky: got %b, required 1", outOverrun); end
        // x = {3, 200}: 558 would mean the dropped 555 entered history, 200 a busy write landed
        drive_strobe(3, FIR, 203, 19);
        wait_idle("overrun_second");
        drive_strobe(7, BYP, 7, 1);
        wait_idle("bypass");
        write_coef(0, 0);
        write_coef(1, 0);
        write_coef(17, 64);
        // y[0] must still be the FIR result 203, not the bypass value 7
        drive_strobe(9, IIR, 203, 27);
        wait_idle("bypass_yhist");
        do_reset();
        nvec++;
        if (outOverrun !== 1'b0) begin nerr++; $display("FAIL overrun_clear: got %b, required 0", outOverrun); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        drive_strobe(11, FIR, 11, 19);
        while (!outSampleValid && n < 40) begin
            @(negedge inClk);
            n++;
        end
        nvec++;
        if (n >= 40) begin nerr++; $display("FAIL b2b_first_timeout: no valid after %0d cycles, required <= 19", n); end
        inSample      = 12'sd22;
        inMode        = FIR;
        inSampleReady = 1'b1;
        sb.push_back('{22, cyc + 19});
        @(negedge inClk);
        inSampleReady = 1'b0;
        nvec++;
        if (outOverrun !== 1'b0 || outBusy !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_accept: overrun=%b busy=%b, required overrun=0 busy=1", outOverrun, outBusy);
        end
        wait_idle("back_to_back");
    endtask

    task automatic test_reset_abort();
        int vc = 0;
        do_reset();
        @(negedge inClk);
        inSample      = 12'sd50;
        inMode        = FIR;
        inSampleReady = 1'b1;
        @(negedge inClk);
        inSampleReady = 1'b0;
        repeat (5) @(negedge inClk);
        inRst_n = 1'b0;
        #1;
        nvec++;
        if (outBusy !== 1'b0 || outSample !== 12'sd0) begin
            nerr++;
            $display("FAIL abort_reset: busy=%b sample=%0d, required busy=0 sample=0", outBusy, outSample);
        end
        repeat (2) @(negedge inClk);
        inRst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge inClk);
            if (outSampleValid) vc++;
        end
        nvec++;
        if (vc !== 0) begin nerr++; $display("FAIL abort_no_valid: got %0d pulses, required 0", vc); end
    endtask

    initial begin
        test_reset();
        test_fir_identity();
        test_fir_impulse();
        test_moving_avg();
        test_saturation();
        test_iir_step();
        test_overrun_bypass();
        test_back_to_back();
        test_reset_abort();
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL leftover_results: %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mac_filter.md
Name: mac_filter

Overview:
- Clocked, time-multiplexed successor of the combinational convolution filter.
- A single multiply-accumulate unit supports runtime-selectable modes: bypass, FIR, IIR (FIR plus feedback) and moving average.
- Tap count, history depth, coefficient width and fixed-point scaling are parametrised; coefficients are runtime-loadable through a write port.
- Sits between the oscillator/mixer sample stream and the DAC stage, driven by the sample-ready strobe.

Parameters:
- SAMPLE_W, 12, signed sample width (in/out).
- COEF_W, 16, signed coefficient width.
- TAPS, 17, feed-forward taps b[0..TAPS-1] applied to x[n-k].
- FB_TAPS, 8, feedback taps a[0..FB_TAPS-1] applied to y[n-1-k].
- FRAC, 6, coefficient fractional bits (Q format); must be >=1.
- AVG_LOG2, 4, moving-average length = 2^AVG_LOG2.
- ACC_W, 40, signed accumulator width.

Ports:
- inClk  in  1  clock; all logic is rising-edge.
- inRst_n  in  1  asynchronous active-low reset.
- inSample  in  SAMPLE_W  signed input sample.
- inSampleReady  in  1  one-cycle strobe, synchronous to inClk; inSample valid in the same cycle.
- inMode  in  2  00 bypass, 01 FIR, 10 IIR, 11 moving average.
- inCoefWe  in  1  coefficient write enable.
- inCoefAddr  in  clog2(TAPS+FB_TAPS)  address: 0..TAPS-1 selects b[k]; TAPS..TAPS+FB_TAPS-1 selects a[k-TAPS].
- inCoefData  in  COEF_W  signed coefficient.
- outSample  out  SAMPLE_W  signed result, held until the next result.
- outSampleValid  out  1  one-cycle pulse when outSample updates.
- outBusy  out  1  high while a computation is in progress.
- outOverrun  out  1  sticky; set when a strobe is dropped.

Behaviour:
- **Reset (async, inRst_n=0):**
  - outSample=0, outSampleValid=0, outBusy=0, outOverrun=0.
  - x and y histories all zero.
  - Coefficients: b[0]=1<<FRAC (identity); every other b and a =0.
  - FSM enters IDLE.
  - Reset asserted mid-operation aborts the computation with no valid pulse.
- **History depth:** HIST = max(TAPS, 2^AVG_LOG2). On an accepted strobe, x shifts and x[0]=inSample.
- **FSM states:** IDLE, FF, FB, ROUND.
- **IDLE, on strobe:**
  - Latch inMode for the whole operation; clear the accumulator; idx=0.
  - Bypass: outSample=inSample next cycle with a valid pulse (latency 1). No FSM state change; y history is not updated.
  - Other modes: go to FF with outBusy=1.
- **FF:**
  - One product per cycle: acc += x[idx]*b[idx]. In moving-average mode, acc += x[idx] with coefficients ignored.
  - Runs TAPS cycles (2^AVG_LOG2 cycles in moving-average mode).
  - Then goes to FB if the mode is IIR, otherwise to ROUND.
- **FB:** acc += y[idx]*a[idx] for FB_TAPS cycles, then ROUND. The sign convention is carried in the coefficients (added, not subtracted).
- **ROUND:**
  - FIR/IIR: r = (acc + (1<<(FRAC-1))) >>> FRAC (round half up).
  - Moving average: r = acc >>> AVG_LOG2 (floor).
  - Saturate r to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - Register outSample, pulse outSampleValid, push the result into y history (y[0]=result), outBusy=0, return to IDLE.
- **Latency (strobe edge to valid pulse):**
  - Bypass: 1.
  - FIR: TAPS+2.
  - IIR: TAPS+FB_TAPS+2.
  - Moving average: 2^AVG_LOG2+2.
- **Overrun:**
  - A strobe while outBusy=1 is dropped: x history and inMode are not sampled, and outOverrun is set.
  - outOverrun clears only on reset.
  - A strobe in the same cycle the FSM returns to IDLE is accepted.
- **Coefficient writes:**
  - Take effect on the next clock edge when outBusy=0.
  - Writes while outBusy=1 are ignored.
  - Addresses at or above TAPS+FB_TAPS are ignored.
- **Arithmetic:**
  - Products are full precision (SAMPLE_W+COEF_W bits), sign-extended to ACC_W.
  - No accumulator overflow handling; ACC_W must cover the worst case.

Test Plan:
1. Reset, then FIR with identity coefficients, inSample=100 -> outSample=100, valid exactly 19 cycles after the strobe; outBusy high in between.
2. Load b[k]=64*(k+1), k=0..16; impulse 1 followed by zeros (FIR) -> outputs 1,2,...,17, then 0.
3. Moving average: sixteen strobes of 160 from reset -> outputs 10,20,...,160; latency 18.
4. b[0]=256 (4.0): input 1000 -> 2047; input -1000 -> -2048 (saturation).
5. IIR, b[0]=32, a[0]=32, others 0; step input 100 from reset -> 50, 75, 88, 94 (round half up verified at 87.5).
6. Second strobe 3 cycles into an FIR computation -> dropped, outOverrun=1, first result unaffected. Bypass strobe afterwards -> output in 1 cycle, y history unchanged. Coefficient write while busy -> ignored.
